// File: rtl/mod4051_rr_scheduler.sv
`default_nettype none
// =============================================================================
// mod4051_rr_scheduler : round-robin sharing of a 100-bit mod-4051 reduction
// core behind a 2-stage valid/ready pipeline. Optional: MOD4051_STATS_EN.
// Revision: 1.0
// =============================================================================
module mod4051_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*100-1:0] req_x,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    output logic [11:0]         res_r,
    output logic [IDW-1:0]      res_id,
    input  logic                res_ready
`ifdef MOD4051_STATS_EN
    ,
    output logic [31:0]         stat_done,
    output logic [15:0]         stat_stall
`endif
);

    // 2**(12k) mod 4051 for each 12-bit chunk of the operand
    localparam logic [11:0] c_W [9] = '{12'd1, 12'd45, 12'd2025, 12'd2003,
                                        12'd1013, 12'd1024, 12'd1519,
                                        12'd3539, 12'd1266};

    logic                r_s1_valid;
    logic [99:0]         r_s1_x;
    logic [IDW-1:0]      r_s1_id;
    logic                r_s2_valid;
    logic [11:0]         r_s2_r;
    logic [IDW-1:0]      r_s2_id;
    logic [IDW-1:0]      r_rr_ptr;

    logic                w_s2_ready;
    logic                w_s1_ready;
    logic                w_found;
    logic [IDW-1:0]      w_gnt_idx;
    logic [NREQ-1:0]     w_grant;
    logic                w_accept;
    logic [99:0]         w_opnd;
    logic [IDW-1:0]      w_ptr_next;
    logic [27:0]         w_sum;
    logic [21:0]         w_f1;
    logic [15:0]         w_f2;
    logic [12:0]         w_f3;
    logic [11:0]         w_core;

    assign w_s2_ready = !r_s2_valid || res_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;

    // Two-pass scan: indices at/above the pointer first, then wrap to those below.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_grant   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (IDW'(i) >= r_rr_ptr)) begin
                w_found    = 1'b1;
                w_gnt_idx  = IDW'(i);
                w_grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (IDW'(i) < r_rr_ptr)) begin
                w_found    = 1'b1;
                w_gnt_idx  = IDW'(i);
                w_grant[i] = 1'b1;
            end
        end
    end

    // Gated by rst_n so no grant is visible while reset is held.
    assign w_accept   = w_found && w_s1_ready && rst_n;
    assign req_ready  = w_accept ? w_grant : '0;
    assign w_ptr_next = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_opnd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_opnd = req_x[i*100 +: 100];
            end
        end
    end

    // Weighted chunk sum, then fold by 4096 == 45 (mod 4051) until < 2*4051.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 8; k++) begin
            w_sum = w_sum + 28'(r_s1_x[12*k +: 12]) * 28'(c_W[k]);
        end
        w_sum  = w_sum + 28'(r_s1_x[99:96]) * 28'(c_W[8]);
        w_f1   = 22'(w_sum[27:12]) * 22'd45 + 22'(w_sum[11:0]);
        w_f2   = 16'(w_f1[21:12]) * 16'd45 + 16'(w_f1[11:0]);
        w_f3   = 13'(w_f2[15:12]) * 13'd45 + 13'(w_f2[11:0]);
        w_core = (w_f3 >= 13'd4051) ? 12'(w_f3 - 13'd4051) : w_f3[11:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_r     <= '0;
            r_s2_id    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_x     <= w_opnd;
                r_s1_id    <= w_gnt_idx;
                r_rr_ptr   <= w_ptr_next;
            end else if (r_s1_valid && w_s2_ready) begin
                r_s1_valid <= 1'b0;
            end

            if (r_s1_valid && w_s2_ready) begin
                r_s2_valid <= 1'b1;
                r_s2_r     <= w_core;
                r_s2_id    <= r_s1_id;
            end else if (w_s2_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_r     = r_s2_r;
    assign res_id    = r_s2_id;

`ifdef MOD4051_STATS_EN
    logic [31:0] r_stat_done;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_done  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (r_s2_valid && res_ready) begin
                r_stat_done <= r_stat_done + 32'd1;
            end
            if (r_s2_valid && !res_ready && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_done  = r_stat_done;
    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod4051_rr_scheduler.sv
`default_nettype none
// Scoreboard bench for mod4051_rr_scheduler: directed stimulus pushes expected
// results; a negedge monitor pops and compares on every retired result.
module tb_mod4051_rr_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [399:0] req_x;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic [11:0]  res_r;
    logic [1:0]   res_id;
    logic         res_ready;
`ifdef MOD4051_STATS_EN
    logic [31:0]  stat_done;
    logic [15:0]  stat_stall;
`endif

    typedef struct {
        logic [1:0]  id;
        logic [11:0] r;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mod4051_rr_scheduler #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_r     (res_r),
        .res_id    (res_id),
        .res_ready (res_ready)
`ifdef MOD4051_STATS_EN
        ,
        .stat_done (stat_done),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int i, input logic [99:0] v);
        req_x[i*100 +: 100] = v;
    endtask

    task automatic push(input logic [1:0] id, input logic [11:0] r);
        exp_t e;
        e.id = id;
        e.r  = r;
        q.push_back(e);
    endtask

    // Monitor: a result retires at the next posedge when valid && ready now.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got id=%0d r=%0d expected none", res_id, res_r);
                end else begin
                    e = q.pop_front();
                    check("res_id", res_id, e.id);
                    check("res_r", res_r, e.r);
                end
            end
        end
    end

    logic [99:0] bvals [4];
    logic [11:0] bexp  [4];

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_res_r", res_r, 0);
        check("rst_res_id", res_id, 0);
        rst_n = 1'b1;
        tick();

        // All four requesters continuously valid: grants rotate 0,1,2,3,0
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_x(i, 100'(100 * (i + 1) + 1));
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 5) ? 4'hF : 4'h0;
            @(negedge clk);
            if (k < 5) begin
                check("rr_grant", req_ready, 4'b0001 << (k % 4));
                push(2'(k % 4), 12'(100 * ((k % 4) + 1) + 1));
            end
            if (k >= 2) check("stream_no_gap", res_valid, 1);
            tick();
        end
        repeat (2) tick();

        // Single request from requester 2, latency 2
        req_valid = 4'b0100;
        set_x(2, 100'd12345);
        @(negedge clk);
        check("single_grant", req_ready, 4'b0100);
        push(2'd2, 12'd192);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("latency_n1", res_valid, 0);
        tick();
        @(negedge clk);
        check("latency_n2", res_valid, 1);
        tick();
        repeat (2) tick();

        // Boundary operands on requester 0
        bvals[0] = 100'd4050;   bexp[0] = 12'd4050;
        bvals[1] = 100'd4051;   bexp[1] = 12'd0;
        bvals[2] = '1;          bexp[2] = 12'd0;
        bvals[3] = {{99{1'b1}}, 1'b0}; bexp[3] = 12'd4050;
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_x(0, bvals[k]);
            @(negedge clk);
            check("bound_grant", req_ready, 4'b0001);
            push(2'd0, bexp[k]);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Backpressure: three pending, only two fit while res_ready=0
        res_ready = 1'b0;
        set_x(1, 100'd4062);
        set_x(2, 100'd8124);
        set_x(3, 100'd33);
        req_valid = 4'b1110;
        @(negedge clk);
        check("bp_grant1", req_ready, 4'b0010);
        push(2'd1, 12'd11);
        tick();
        req_valid = 4'b1100;
        @(negedge clk);
        check("bp_grant2", req_ready, 4'b0100);
        push(2'd2, 12'd22);
        tick();
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_blocked", req_ready, 0);
            check("bp_valid", res_valid, 1);
            check("bp_hold_r", res_r, 11);
            check("bp_hold_id", res_id, 1);
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_grant3", req_ready, 4'b1000);
        push(2'd3, 12'd33);
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset with both stages occupied
        res_ready = 1'b0;
        set_x(1, 100'd4062);
        set_x(2, 100'd8124);
        req_valid = 4'b0110;
        repeat (2) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_res_r", res_r, 0);
        check("mid_rst_res_id", res_id, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        set_x(0, 100'd101);
        req_valid = 4'hF;
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        push(2'd0, 12'd101);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) tick();

`ifdef MOD4051_STATS_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        set_x(0, 100'd7);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stat_grant", req_ready, 4'b0001);
            push(2'd0, 12'd7);
            tick();
        end
        req_valid = '0;
        res_ready = 1'b0;
        repeat (5) tick();
        res_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("stat_done", stat_done, 10);
        check("stat_stall", stat_stall, 5);
        tick();
`endif

        for (int t = 0; t < 50 && q.size() != 0; t++) tick();
        check("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
